axil_periph_demux: RTL and testbench
====================================

Name: axil_periph_demux

Overview:
- 1-to-N AXI4-Lite demultiplexer between the CPU-side AXI4-Lite master and the peripheral slaves (timer, GPIO, UART, ...).
- Decodes each write/read address into a slave slot, forwards the transaction to that slave, and returns its response to the master.
- Unmapped addresses complete locally with DECERR.
- Write and read paths are independent FSMs; each allows one outstanding transaction.

Parameters:
- NUM_SLAVES, 4, number of peripheral slots (power of two, 1..16).
- BASE_ADDR, 32'h2000_0000, base of the peripheral window.
- SLOT_BITS, 12, log2 of slot size (4 KiB per slave).

Ports:
- s_axi_aclk  in  1  clock
- s_axi_aresetn  in  1  async active-low reset
- s_axi_awaddr/awvalid/awready  in/in/out  32/1/1  master write address
- s_axi_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  master write data
- s_axi_bresp/bvalid/bready  out/out/in  2/1/1  master write response
- s_axi_araddr/arvalid/arready  in/in/out  32/1/1  master read address
- s_axi_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  master read data
- m_axi_awaddr/wdata/wstrb  out  32/32/4  shared to all slaves, registered
- m_axi_awvalid/awready/wvalid/wready  out/in/out/in  N each  per-slave write handshakes
- m_axi_bresp/bvalid/bready  in/in/out  2N/N/N  per-slave write responses
- m_axi_araddr  out  32  shared, registered
- m_axi_arvalid/arready  out/in  N  per-slave read address
- m_axi_rdata/rresp/rvalid/rready  in/in/in/out  32N/2N/N/N  per-slave read data

Behaviour:
- Reset: s_axi_aresetn is asynchronous, active-low; clock is s_axi_aclk.
  - All ready/valid outputs 0; bresp/rresp 0; rdata 0; m_axi_awaddr/wdata/wstrb/araddr 0.
  - Both FSMs return to IDLE.
  - Reset mid-transaction drops it silently; there is no response to the master.
- Decode:
  - Hit when addr[31:SLOT_BITS+log2(N)] == BASE_ADDR[31:SLOT_BITS+log2(N)].
  - idx = addr[SLOT_BITS +: log2(N)].
  - The full 32-bit address is forwarded unmodified.
- Write FSM (W_IDLE, W_REQ, W_RESP, W_BACK):
  - W_IDLE:
    - When awvalid&&wvalid both high, pulse awready and wready together for 1 cycle.
    - Register addr/data/strb and idx.
    - Hit -> W_REQ; miss -> W_BACK with bresp=DECERR (2'b11).
    - AW alone or W alone is never accepted.
  - W_REQ:
    - m_awvalid[idx] and m_wvalid[idx] assert on the cycle after acceptance.
    - Each drops independently on its own ready.
    - When both channels are done -> W_RESP.
  - W_RESP:
    - m_bready[idx]=1.
    - On m_bvalid[idx], capture bresp -> W_BACK.
  - W_BACK:
    - s_bvalid=1 with captured resp, held until s_bready -> W_IDLE.
- Read FSM (R_IDLE, R_REQ, R_RESP, R_BACK):
  - Mirrors the write FSM: arready pulse on arvalid, m_arvalid[idx] until m_arready[idx].
  - Captures rdata/rresp on m_rvalid[idx]; holds s_rvalid until s_rready.
  - Miss: rdata=0, rresp=DECERR.
- Handshake rules:
  - Only the selected slot's valid/ready bits may be 1; all others are 0.
  - A slave asserting bvalid/rvalid while not selected in the RESP state is ignored (its ready stays 0).
- Concurrency: a read and a write may run concurrently, to the same or different slots.
- Latency: s_aw handshake at edge T; m_awvalid visible after T. Minimum master-to-master write/read round trip is 4 cycles with zero-wait slaves.
- No combinational path from any input to any output.

Optional Feature:
- AXIL_DEMUX_TIMEOUT_EN defined:
  - Per-FSM 16-bit watchdog, loaded with 1023 on entering REQ, decremented each cycle in REQ/RESP.
  - At 0: drop all m_ valids/readies, respond SLVERR (2'b10), rdata=0, go to BACK.
  - A late slave response is then ignored.
- Undefined: no watchdog; the FSM waits indefinitely.

Decomposition:
- axil_pkg:
  - Response constants RESP_OKAY/EXOKAY/SLVERR/DECERR.
  - wr_state_e and rd_state_e enums.
  - TIMEOUT_CYCLES constant.
- Sub-module axil_addr_decode (combinational: addr -> hit, idx), instantiated twice (AW, AR).

Test Plan:
- Write 0x2000_0004 data 0x0000_00FF, zero-wait slave 0 -> m_awvalid=4'b0001, m_wdata=0xFF, s_bresp=OKAY, 4-cycle round trip.
- Read 0x2000_1014, slave 1 returns 0x1234 -> m_arvalid=4'b0010, s_rdata=0x1234, rresp=OKAY; other m_arvalid bits 0 throughout.
- Read/write 0x3000_0000 -> no m_ valid ever, rresp/bresp=2'b11, rdata=0.
- Concurrent write slot 2 and read slot 3, slave 2 holds awready low 5 cycles -> read completes independently; write completes after slave accepts.
- s_bready/s_rready held low 6 cycles -> bvalid/rvalid and captured data stable; next transaction is not accepted until the handshake completes.
- With AXIL_DEMUX_TIMEOUT_EN, slave 0 never asserts bvalid -> SLVERR after 1024 cycles; assert reset during W_RESP -> all outputs 0 immediately.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite peripheral demux: response codes, FSM states, watchdog reload.
// No logic, so no latency.
// No handshakes of its own.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP, W_BACK} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_REQ, R_RESP, R_BACK} rd_state_e;

  // Watchdog reload value; expiry happens TIMEOUT_CYCLES+1 cycles after entering REQ.
  localparam logic [15:0] TIMEOUT_CYCLES = 16'd1023;

endpackage

// File: rtl/axil_addr_decode.sv
// Address decoder: maps a 32-bit address to a hit flag and a slave slot index.
// Purely combinational, zero latency.
// No handshakes; the caller registers the result on acceptance.
module axil_addr_decode
  import axil_pkg::*;
#(
  parameter int          NUM_SLAVES = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h2000_0000,
  parameter int          SLOT_BITS  = 12,
  parameter int          IDX_W      = 2
) (
  input  logic [31:0]      addr,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  localparam int          LOG2N   = $clog2(NUM_SLAVES);
  localparam int          HI_LSB  = SLOT_BITS + LOG2N;
  // Bits above the whole peripheral window must match the base address.
  localparam logic [31:0] HI_MASK = ~((32'd1 << HI_LSB) - 32'd1);

  assign hit = (((addr ^ BASE_ADDR) & HI_MASK) == 32'd0);

  // Slot index is the field right above the per-slave offset; a single slave is always slot 0.
  always_comb begin
    idx = '0;
    for (int i = 0; i < IDX_W; i++) begin
      if (i < LOG2N) idx[i] = addr[SLOT_BITS+i];
    end
  end

endmodule

// File: rtl/axil_periph_demux.sv
// 1-to-N AXI4-Lite demux; independent write/read FSMs, one outstanding each; misses answer DECERR locally.
// Latency: 4 cycles master-valid to master-response with zero-wait slaves; all outputs registered.
// Backpressure: master held off until the previous response is taken; AXIL_DEMUX_TIMEOUT_EN adds a SLVERR watchdog.
module axil_periph_demux
  import axil_pkg::*;
#(
  parameter int          NUM_SLAVES = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h2000_0000,
  parameter int          SLOT_BITS  = 12
) (
  input  logic                     s_axi_aclk,
  input  logic                     s_axi_aresetn,
  input  logic [31:0]              s_axi_awaddr,
  input  logic                     s_axi_awvalid,
  output logic                     s_axi_awready,
  input  logic [31:0]              s_axi_wdata,
  input  logic [3:0]               s_axi_wstrb,
  input  logic                     s_axi_wvalid,
  output logic                     s_axi_wready,
  output logic [1:0]               s_axi_bresp,
  output logic                     s_axi_bvalid,
  input  logic                     s_axi_bready,
  input  logic [31:0]              s_axi_araddr,
  input  logic                     s_axi_arvalid,
  output logic                     s_axi_arready,
  output logic [31:0]              s_axi_rdata,
  output logic [1:0]               s_axi_rresp,
  output logic                     s_axi_rvalid,
  input  logic                     s_axi_rready,
  output logic [31:0]              m_axi_awaddr,
  output logic [31:0]              m_axi_wdata,
  output logic [3:0]               m_axi_wstrb,
  output logic [NUM_SLAVES-1:0]    m_axi_awvalid,
  input  logic [NUM_SLAVES-1:0]    m_axi_awready,
  output logic [NUM_SLAVES-1:0]    m_axi_wvalid,
  input  logic [NUM_SLAVES-1:0]    m_axi_wready,
  input  logic [2*NUM_SLAVES-1:0]  m_axi_bresp,
  input  logic [NUM_SLAVES-1:0]    m_axi_bvalid,
  output logic [NUM_SLAVES-1:0]    m_axi_bready,
  output logic [31:0]              m_axi_araddr,
  output logic [NUM_SLAVES-1:0]    m_axi_arvalid,
  input  logic [NUM_SLAVES-1:0]    m_axi_arready,
  input  logic [32*NUM_SLAVES-1:0] m_axi_rdata,
  input  logic [2*NUM_SLAVES-1:0]  m_axi_rresp,
  input  logic [NUM_SLAVES-1:0]    m_axi_rvalid,
  output logic [NUM_SLAVES-1:0]    m_axi_rready
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  wr_state_e             w_state;
  rd_state_e             r_state;
  logic                  aw_acc;
  logic                  ar_acc;
  logic [NUM_SLAVES-1:0] w_sel;
  logic [NUM_SLAVES-1:0] r_sel;

  logic                  aw_hit, ar_hit;
  logic [IDX_W-1:0]      aw_idx, ar_idx;
  logic [NUM_SLAVES-1:0] aw_sel_c, ar_sel_c;
  logic [1:0]            sel_bresp, sel_rresp;
  logic [31:0]           sel_rdata;
  logic                  b_fire, r_fire;
  logic                  w_expired, r_expired;

  axil_addr_decode #(
    .NUM_SLAVES(NUM_SLAVES), .BASE_ADDR(BASE_ADDR), .SLOT_BITS(SLOT_BITS), .IDX_W(IDX_W)
  ) u_aw_dec (
    .addr(s_axi_awaddr), .hit(aw_hit), .idx(aw_idx)
  );

  axil_addr_decode #(
    .NUM_SLAVES(NUM_SLAVES), .BASE_ADDR(BASE_ADDR), .SLOT_BITS(SLOT_BITS), .IDX_W(IDX_W)
  ) u_ar_dec (
    .addr(s_axi_araddr), .hit(ar_hit), .idx(ar_idx)
  );

  // The same register accepts AW and W so neither channel is ever taken alone.
  assign s_axi_awready = aw_acc;
  assign s_axi_wready  = aw_acc;
  assign s_axi_arready = ar_acc;

  // Only the owning slot has its ready raised, so any other slave's response is masked here.
  assign b_fire = |(m_axi_bvalid & m_axi_bready);
  assign r_fire = |(m_axi_rvalid & m_axi_rready);

  // One-hot slot selects from the decoded indices, and response muxes from the latched selects.
  always_comb begin
    aw_sel_c  = '0;
    ar_sel_c  = '0;
    sel_bresp = '0;
    sel_rresp = '0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      aw_sel_c[i] = (aw_idx == IDX_W'(i));
      ar_sel_c[i] = (ar_idx == IDX_W'(i));
      if (w_sel[i]) sel_bresp = m_axi_bresp[2*i +: 2];
      if (r_sel[i]) begin
        sel_rresp = m_axi_rresp[2*i +: 2];
        sel_rdata = m_axi_rdata[32*i +: 32];
      end
    end
  end

`ifdef AXIL_DEMUX_TIMEOUT_EN
  logic [15:0] w_dog;
  logic [15:0] r_dog;

  assign w_expired = (w_dog == 16'd0);
  assign r_expired = (r_dog == 16'd0);

  // Write watchdog: reload on a hitting acceptance, count down while waiting on the slave.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      w_dog <= TIMEOUT_CYCLES;
    end else if (w_state == W_IDLE && aw_acc && aw_hit) begin
      w_dog <= TIMEOUT_CYCLES;
    end else if ((w_state == W_REQ || w_state == W_RESP) && !w_expired) begin
      w_dog <= w_dog - 16'd1;
    end
  end

  // Read watchdog, same scheme as the write side.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_dog <= TIMEOUT_CYCLES;
    end else if (r_state == R_IDLE && ar_acc && ar_hit) begin
      r_dog <= TIMEOUT_CYCLES;
    end else if ((r_state == R_REQ || r_state == R_RESP) && !r_expired) begin
      r_dog <= r_dog - 16'd1;
    end
  end
`else
  assign w_expired = 1'b0;
  assign r_expired = 1'b0;
`endif

  // Write FSM: accept AW+W together, forward to the slot, collect B, hand it back to the master.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      w_state       <= W_IDLE;
      aw_acc        <= 1'b0;
      w_sel         <= '0;
      m_axi_awaddr  <= '0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_awvalid <= '0;
      m_axi_wvalid  <= '0;
      m_axi_bready  <= '0;
      s_axi_bresp   <= RESP_OKAY;
      s_axi_bvalid  <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_acc) begin
            // Handshake completes on this edge; the master keeps address and data stable until then.
            aw_acc       <= 1'b0;
            m_axi_awaddr <= s_axi_awaddr;
            m_axi_wdata  <= s_axi_wdata;
            m_axi_wstrb  <= s_axi_wstrb;
            w_sel        <= aw_sel_c;
            if (aw_hit) begin
              m_axi_awvalid <= aw_sel_c;
              m_axi_wvalid  <= aw_sel_c;
              w_state       <= W_REQ;
            end else begin
              s_axi_bresp  <= RESP_DECERR;
              s_axi_bvalid <= 1'b1;
              w_state      <= W_BACK;
            end
          end else if (s_axi_awvalid && s_axi_wvalid) begin
            aw_acc <= 1'b1;
          end
        end
        W_REQ: begin
          if (w_expired) begin
            m_axi_awvalid <= '0;
            m_axi_wvalid  <= '0;
            s_axi_bresp   <= RESP_SLVERR;
            s_axi_bvalid  <= 1'b1;
            w_state       <= W_BACK;
          end else begin
            // AW and W retire independently; move on once neither is still pending.
            m_axi_awvalid <= m_axi_awvalid & ~m_axi_awready;
            m_axi_wvalid  <= m_axi_wvalid & ~m_axi_wready;
            if ((m_axi_awvalid & ~m_axi_awready) == '0 && (m_axi_wvalid & ~m_axi_wready) == '0) begin
              m_axi_bready <= w_sel;
              w_state      <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (w_expired) begin
            m_axi_bready <= '0;
            s_axi_bresp  <= RESP_SLVERR;
            s_axi_bvalid <= 1'b1;
            w_state      <= W_BACK;
          end else if (b_fire) begin
            m_axi_bready <= '0;
            s_axi_bresp  <= sel_bresp;
            s_axi_bvalid <= 1'b1;
            w_state      <= W_BACK;
          end
        end
        W_BACK: begin
          if (s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
            w_state      <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read FSM: accept AR, forward to the slot, capture R, hand it back to the master.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_state       <= R_IDLE;
      ar_acc        <= 1'b0;
      r_sel         <= '0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= '0;
      m_axi_rready  <= '0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= RESP_OKAY;
      s_axi_rvalid  <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_acc) begin
            ar_acc       <= 1'b0;
            m_axi_araddr <= s_axi_araddr;
            r_sel        <= ar_sel_c;
            if (ar_hit) begin
              m_axi_arvalid <= ar_sel_c;
              r_state       <= R_REQ;
            end else begin
              s_axi_rdata  <= '0;
              s_axi_rresp  <= RESP_DECERR;
              s_axi_rvalid <= 1'b1;
              r_state      <= R_BACK;
            end
          end else if (s_axi_arvalid) begin
            ar_acc <= 1'b1;
          end
        end
        R_REQ: begin
          if (r_expired) begin
            m_axi_arvalid <= '0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= RESP_SLVERR;
            s_axi_rvalid  <= 1'b1;
            r_state       <= R_BACK;
          end else begin
            m_axi_arvalid <= m_axi_arvalid & ~m_axi_arready;
            if ((m_axi_arvalid & ~m_axi_arready) == '0) begin
              m_axi_rready <= r_sel;
              r_state      <= R_RESP;
            end
          end
        end
        R_RESP: begin
          if (r_expired) begin
            m_axi_rready <= '0;
            s_axi_rdata  <= '0;
            s_axi_rresp  <= RESP_SLVERR;
            s_axi_rvalid <= 1'b1;
            r_state      <= R_BACK;
          end else if (r_fire) begin
            m_axi_rready <= '0;
            s_axi_rdata  <= sel_rdata;
            s_axi_rresp  <= sel_rresp;
            s_axi_rvalid <= 1'b1;
            r_state      <= R_BACK;
          end
        end
        R_BACK: begin
          if (s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
            r_state      <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_periph_demux.sv
// Directed bench for axil_periph_demux with reactive slave models and response scoreboards.
// Master-side tasks drive one transaction at a time per channel; slaves respond after their handshakes.
// Slave stalls and a never-responding slave exercise backpressure, isolation, misses and reset.
module tb_axil_periph_demux;

  localparam int N = 4;

  logic              clk;
  logic              aresetn;
  logic [31:0]       s_axi_awaddr;
  logic              s_axi_awvalid;
  logic              s_axi_awready;
  logic [31:0]       s_axi_wdata;
  logic [3:0]        s_axi_wstrb;
  logic              s_axi_wvalid;
  logic              s_axi_wready;
  logic [1:0]        s_axi_bresp;
  logic              s_axi_bvalid;
  logic              s_axi_bready;
  logic [31:0]       s_axi_araddr;
  logic              s_axi_arvalid;
  logic              s_axi_arready;
  logic [31:0]       s_axi_rdata;
  logic [1:0]        s_axi_rresp;
  logic              s_axi_rvalid;
  logic              s_axi_rready;
  logic [31:0]       m_axi_awaddr;
  logic [31:0]       m_axi_wdata;
  logic [3:0]        m_axi_wstrb;
  logic [N-1:0]      m_axi_awvalid;
  logic [N-1:0]      m_axi_awready;
  logic [N-1:0]      m_axi_wvalid;
  logic [N-1:0]      m_axi_wready;
  logic [2*N-1:0]    m_axi_bresp;
  logic [N-1:0]      m_axi_bvalid;
  logic [N-1:0]      m_axi_bready;
  logic [31:0]       m_axi_araddr;
  logic [N-1:0]      m_axi_arvalid;
  logic [N-1:0]      m_axi_arready;
  logic [32*N-1:0]   m_axi_rdata;
  logic [2*N-1:0]    m_axi_rresp;
  logic [N-1:0]      m_axi_rvalid;
  logic [N-1:0]      m_axi_rready;

  axil_periph_demux #(
    .NUM_SLAVES(N), .BASE_ADDR(32'h2000_0000), .SLOT_BITS(12)
  ) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(aresetn),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Scoreboards: expected master-side responses, pushed at issue time.
  logic [1:0]  wq[$];
  logic [33:0] rq[$];

  // Slave configuration (owned by the main sequence).
  int          aw_stall_cfg[N];
  bit          b_never[N];
  logic [31:0] slave_rdata[N];
  int          epoch = 0;

  // Slave model state (owned by the model process).
  bit          got_aw[N];
  bit          got_w[N];
  int          aw_wait[N];
  logic [N-1:0] seen_aw, seen_w, seen_ar;
  int          seen_epoch;

  int t_wr, b_cyc, r_cyc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout reached cycle %0d", cyc);
    $fatal(1, "global timeout");
  end

  // Reactive slave models: sample handshakes mid-cycle, update responses just after the edge.
  initial begin
    logic [N-1:0] aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_v;
    m_axi_awready = '0; m_axi_wready = '0; m_axi_bresp = '0; m_axi_bvalid = '0;
    m_axi_arready = '0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rvalid = '0;
    seen_aw = '0; seen_w = '0; seen_ar = '0; seen_epoch = 0;
    for (int s = 0; s < N; s++) begin got_aw[s] = 0; got_w[s] = 0; aw_wait[s] = 0; end
    forever begin
      @(negedge clk);
      if (epoch != seen_epoch) begin
        seen_aw = '0; seen_w = '0; seen_ar = '0; seen_epoch = epoch;
      end
      seen_aw |= m_axi_awvalid;
      seen_w  |= m_axi_wvalid;
      seen_ar |= m_axi_arvalid;
      aw_hs = m_axi_awvalid & m_axi_awready;
      w_hs  = m_axi_wvalid & m_axi_wready;
      b_hs  = m_axi_bvalid & m_axi_bready;
      ar_hs = m_axi_arvalid & m_axi_arready;
      r_hs  = m_axi_rvalid & m_axi_rready;
      aw_v  = m_axi_awvalid;
      @(posedge clk);
      #1;
      if (!aresetn) begin
        m_axi_bvalid = '0; m_axi_rvalid = '0;
        for (int s = 0; s < N; s++) begin got_aw[s] = 0; got_w[s] = 0; aw_wait[s] = 0; end
      end else begin
        for (int s = 0; s < N; s++) begin
          if (aw_hs[s]) begin got_aw[s] = 1; aw_wait[s] = 0; end
          else if (aw_v[s]) aw_wait[s]++;
          if (w_hs[s]) got_w[s] = 1;
          if (b_hs[s]) m_axi_bvalid[s] = 1'b0;
          if (got_aw[s] && got_w[s] && !b_never[s] && !m_axi_bvalid[s]) begin
            m_axi_bvalid[s] = 1'b1;
            m_axi_bresp[2*s +: 2] = 2'b00;
            got_aw[s] = 0; got_w[s] = 0;
          end
          if (r_hs[s]) m_axi_rvalid[s] = 1'b0;
          if (ar_hs[s]) begin
            m_axi_rvalid[s] = 1'b1;
            m_axi_rdata[32*s +: 32] = slave_rdata[s];
            m_axi_rresp[2*s +: 2] = 2'b00;
          end
        end
      end
      for (int s = 0; s < N; s++) m_axi_awready[s] = (aw_wait[s] >= aw_stall_cfg[s]);
      m_axi_wready  = '1;
      m_axi_arready = '1;
    end
  end

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] exp, input string tag);
    int n;
    wq.push_back(exp);
    t_wr = cyc;
    s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!s_axi_awready && n < 200);
    chk({tag, "_awready"}, {s_axi_awready, s_axi_wready}, 2'b11);
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
  endtask

  task automatic wr_finish(input int hold, input string tag);
    int n;
    bit ok;
    logic [1:0] exp;
    n = 0;
    while (!s_axi_bvalid && n < 3000) begin @(posedge clk); #1; n++; end
    chk({tag, "_bvalid"}, s_axi_bvalid, 1'b1);
    b_cyc = cyc;
    exp = (wq.size() > 0) ? wq.pop_front() : 2'bxx;
    ok = 1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (!(s_axi_bvalid === 1'b1 && s_axi_bresp === exp && s_axi_awready === 1'b0)) ok = 0;
    end
    if (hold > 0) chk({tag, "_hold"}, ok, 1'b1);
    chk({tag, "_bresp"}, s_axi_bresp, exp);
    s_axi_bready = 1'b1;
    @(posedge clk); #1;
    s_axi_bready = 1'b0;
    chk({tag, "_bdone"}, s_axi_bvalid, 1'b0);
  endtask

  task automatic rd_issue(input logic [31:0] a, input logic [1:0] exp_resp,
                          input logic [31:0] exp_data, input string tag);
    int n;
    rq.push_back({exp_resp, exp_data});
    s_axi_araddr = a; s_axi_arvalid = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!s_axi_arready && n < 200);
    chk({tag, "_arready"}, s_axi_arready, 1'b1);
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
  endtask

  task automatic rd_finish(input int hold, input string tag);
    int n;
    bit ok;
    logic [33:0] exp;
    n = 0;
    while (!s_axi_rvalid && n < 3000) begin @(posedge clk); #1; n++; end
    chk({tag, "_rvalid"}, s_axi_rvalid, 1'b1);
    r_cyc = cyc;
    exp = (rq.size() > 0) ? rq.pop_front() : 34'bx;
    ok = 1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (!(s_axi_rvalid === 1'b1 && {s_axi_rresp, s_axi_rdata} === exp && s_axi_arready === 1'b0)) ok = 0;
    end
    if (hold > 0) chk({tag, "_hold"}, ok, 1'b1);
    chk({tag, "_rresp_rdata"}, {s_axi_rresp, s_axi_rdata}, exp);
    s_axi_rready = 1'b1;
    @(posedge clk); #1;
    s_axi_rready = 1'b0;
    chk({tag, "_rdone"}, s_axi_rvalid, 1'b0);
  endtask

  function automatic logic [191:0] all_outs();
    return {31'd0, s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid, s_axi_arready,
            s_axi_rdata, s_axi_rresp, s_axi_rvalid, m_axi_awaddr, m_axi_wdata, m_axi_wstrb,
            m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_araddr, m_axi_arvalid, m_axi_rready};
  endfunction

  initial begin
    int n;
    aresetn = 1'b0;
    s_axi_awaddr = '0; s_axi_awvalid = 0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 0;
    s_axi_bready = 0; s_axi_araddr = '0; s_axi_arvalid = 0; s_axi_rready = 0;
    for (int s = 0; s < N; s++) begin aw_stall_cfg[s] = 0; b_never[s] = 0; slave_rdata[s] = '0; end

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", all_outs(), '0);
    aresetn = 1'b1;
    @(posedge clk); #1;

    // Write to slot 0, zero-wait slave, 4-cycle round trip.
    epoch++;
    wr_issue(32'h2000_0004, 32'h0000_00FF, 4'hF, 2'b00, "wr0");
    chk("wr0_m_awvalid", m_axi_awvalid, 4'b0001);
    chk("wr0_m_wvalid", m_axi_wvalid, 4'b0001);
    chk("wr0_m_bus", {m_axi_awaddr, m_axi_wdata, m_axi_wstrb}, {32'h2000_0004, 32'h0000_00FF, 4'hF});
    wr_finish(0, "wr0");
    chk("wr0_latency", b_cyc - t_wr, 4);
    chk("wr0_seen_aw", seen_aw, 4'b0001);

    // Read from slot 1.
    slave_rdata[1] = 32'h0000_1234;
    epoch++;
    rd_issue(32'h2000_1014, 2'b00, 32'h0000_1234, "rd1");
    chk("rd1_m_arvalid", m_axi_arvalid, 4'b0010);
    chk("rd1_m_araddr", m_axi_araddr, 32'h2000_1014);
    rd_finish(0, "rd1");
    chk("rd1_seen_ar", seen_ar, 4'b0010);

    // Unmapped addresses: DECERR, zero data, no slave touched.
    epoch++;
    wr_issue(32'h3000_0000, 32'hDEAD_BEEF, 4'hF, 2'b11, "wrmiss");
    wr_finish(0, "wrmiss");
    rd_issue(32'h3000_0000, 2'b11, 32'h0, "rdmiss");
    rd_finish(0, "rdmiss");
    rd_issue(32'h2000_4000, 2'b11, 32'h0, "rdabove");
    rd_finish(0, "rdabove");
    rd_issue(32'h1FFF_FFFC, 2'b11, 32'h0, "rdbelow");
    rd_finish(0, "rdbelow");
    chk("miss_seen", {seen_aw, seen_w, seen_ar}, 12'h000);

    // Last word of the window lands in slot 3.
    slave_rdata[3] = 32'h3333_FFFC;
    epoch++;
    rd_issue(32'h2000_3FFC, 2'b00, 32'h3333_FFFC, "rdtop");
    rd_finish(0, "rdtop");
    chk("rdtop_seen_ar", seen_ar, 4'b1000);

    // Concurrent write to slot 2 (AW stalled) and read from slot 3.
    aw_stall_cfg[2] = 5;
    slave_rdata[3] = 32'hCAFE_F00D;
    epoch++;
    fork
      begin
        wr_issue(32'h2000_2000, 32'h0000_A5A5, 4'h3, 2'b00, "wr2");
        wr_finish(0, "wr2");
      end
      begin
        rd_issue(32'h2000_3008, 2'b00, 32'hCAFE_F00D, "rd3");
        rd_finish(0, "rd3");
      end
    join
    chk("conc_read_first", r_cyc < b_cyc, 1'b1);
    chk("conc_seen", {seen_aw, seen_ar}, {4'b0100, 4'b1000});
    aw_stall_cfg[2] = 0;

    // Master backpressure: responses held stable, next request held off.
    wr_issue(32'h2000_0010, 32'h0000_0055, 4'hF, 2'b00, "wrhold");
    s_axi_awaddr = 32'h2000_1000; s_axi_wdata = 32'h0000_0066; s_axi_awvalid = 1; s_axi_wvalid = 1;
    wr_finish(6, "wrhold");
    wr_issue(32'h2000_1000, 32'h0000_0066, 4'hF, 2'b00, "wrnext");
    chk("wrnext_m_awvalid", m_axi_awvalid, 4'b0010);
    wr_finish(0, "wrnext");
    slave_rdata[1] = 32'h0BAD_F00D;
    rd_issue(32'h2000_1000, 2'b00, 32'h0BAD_F00D, "rdhold");
    s_axi_araddr = 32'h2000_2004; s_axi_arvalid = 1;
    slave_rdata[2] = 32'h2222_0004;
    rd_finish(6, "rdhold");
    rd_issue(32'h2000_2004, 2'b00, 32'h2222_0004, "rdnext");
    rd_finish(0, "rdnext");

`ifdef AXIL_DEMUX_TIMEOUT_EN
    // Slave 0 never responds: watchdog answers SLVERR.
    b_never[0] = 1;
    wr_issue(32'h2000_0000, 32'h0000_0001, 4'hF, 2'b10, "wrto");
    wr_finish(0, "wrto");
    chk("wrto_latency", b_cyc - t_wr, 1026);
    chk("wrto_bready_dropped", m_axi_bready, 4'b0000);
`endif

    // Reset while waiting for a write response drops everything immediately.
    b_never[0] = 1;
    wr_issue(32'h2000_0020, 32'h0000_0077, 4'hF, 2'b00, "wrrst");
    n = 0;
    while (m_axi_bready !== 4'b0001 && n < 50) begin @(posedge clk); #1; n++; end
    chk("wrrst_in_resp", m_axi_bready, 4'b0001);
    #2;
    aresetn = 1'b0;
    #1;
    chk("wrrst_outputs", all_outs(), '0);
    if (wq.size() > 0) void'(wq.pop_front());
    repeat (2) @(posedge clk);
    #1;
    b_never[0] = 0;
    aresetn = 1'b1;
    @(posedge clk); #1;
    wr_issue(32'h2000_0008, 32'h0000_0088, 4'hF, 2'b00, "wrpost");
    wr_finish(0, "wrpost");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
